// File: rtl/cvp14_mem_pkg.sv
// Shared types and constants for the CVP14 single-clock memory responder.
package cvp14_mem_pkg;

  localparam int CVP14_ADDR_W = 16;
  localparam int CVP14_DATA_W = 16;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'b00,
    BUS_READ  = 2'b01,
    BUS_WRITE = 2'b10,
    BUS_COLL  = 2'b11
  } bus_op_t;

  function automatic bus_op_t decode_op(input logic rd, input logic wr);
    bus_op_t op;
    case ({rd, wr})
      2'b10:   op = BUS_READ;
      2'b01:   op = BUS_WRITE;
      2'b11:   op = BUS_COLL;
      default: op = BUS_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Fixed-latency valid+data shift register carrying read words to the bus.
module mem_rd_pipe #(
  parameter int LAT    = 2,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              flush_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LAT-1:0]             valid_r;
  logic [LAT-1:0][DATA_W-1:0] data_r;

  // Shift stages forward each cycle; flush drops every in-flight entry.
  always_ff @(posedge clk or negedge flush_n) begin
    if (!flush_n) begin
      valid_r <= {LAT{1'b0}};
      data_r  <= {(LAT*DATA_W){1'b0}};
    end else begin
      valid_r[0] <= in_valid;
      data_r[0]  <= in_data;
      for (int i = 1; i < LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
        data_r[i]  <= data_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[LAT-1];
  assign out_data  = data_r[LAT-1];

endmodule

// File: rtl/cvp14_mem_responder.sv
// CVP14 memory responder: word array, per-cycle op decode, sticky error,
// fixed-latency read return and a registered back-door read port.
module cvp14_mem_responder
  import cvp14_mem_pkg::*;
#(
  parameter int ADDR_W   = CVP14_ADDR_W,
  parameter int DATA_W   = CVP14_DATA_W,
  parameter int DEPTH    = 65536,
  parameter int READ_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              RD,
  input  logic              WR,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              RdValid,
  output logic              Error,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData
);

  localparam int LAT_C = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                         (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;
  logic              error_r;
  logic [DATA_W-1:0] dbg_data_r;

  bus_op_t           bus_op_s;
  logic              in_range_s;
  logic              dbg_in_range_s;
  logic [IDX_W-1:0]  addr_idx_s;
  logic [IDX_W-1:0]  dbg_idx_s;
  logic              rd_en_s;
  logic              wr_en_s;
  logic              wr_go_s;
  logic              err_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [DATA_W-1:0] dbg_word_s;
  logic              pipe_valid_s;
  logic [DATA_W-1:0] pipe_data_s;

  assign addr_idx_s = Addr[IDX_W-1:0];
  assign dbg_idx_s  = DbgAddr[IDX_W-1:0];

  // Decode the bus op, range-check both ports and fetch the addressed words.
  always_comb begin
    bus_op_s       = decode_op(RD, WR);
    in_range_s     = ({1'b0, Addr} < DEPTH_C);
    dbg_in_range_s = ({1'b0, DbgAddr} < DEPTH_C);
    rd_en_s        = 1'b0;
    wr_en_s        = 1'b0;
    err_s          = 1'b0;
    case (bus_op_s)
      BUS_READ: begin
        rd_en_s = 1'b1;
        err_s   = ~in_range_s;
      end
      BUS_WRITE: begin
        wr_en_s = in_range_s;
        err_s   = ~in_range_s;
      end
      BUS_COLL: begin
        wr_en_s = in_range_s;
        err_s   = 1'b1;
      end
      default: begin
        rd_en_s = 1'b0;
        wr_en_s = 1'b0;
        err_s   = 1'b0;
      end
    endcase
    // A write that coincides with reset being held low is discarded.
    wr_go_s = wr_en_s & Reset_n;
    if (in_range_s) begin
      rd_word_s = mem_r[addr_idx_s];
    end else begin
      rd_word_s = {DATA_W{1'b0}};
    end
    if (dbg_in_range_s) begin
      dbg_word_s = mem_r[dbg_idx_s];
    end else begin
      dbg_word_s = {DATA_W{1'b0}};
    end
  end

  // Array write port; contents survive reset.
  always_ff @(posedge Clk) begin
    if (wr_go_s) begin
      mem_r[addr_idx_s] <= WrData;
    end
  end

  mem_rd_pipe #(
    .LAT    (LAT_C),
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .clk       (Clk),
    .flush_n   (Reset_n),
    .in_valid  (rd_en_s),
    .in_data   (rd_word_s),
    .out_valid (pipe_valid_s),
    .out_data  (pipe_data_s)
  );

  // Bus return, sticky error and back-door data registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
      error_r    <= 1'b0;
      dbg_data_r <= {DATA_W{1'b0}};
    end else begin
      rd_valid_r <= pipe_valid_s;
      if (pipe_valid_s) begin
        rd_data_r <= pipe_data_s;
      end else begin
        rd_data_r <= rd_data_r;
      end
      error_r    <= error_r | err_s;
      dbg_data_r <= dbg_word_s;
    end
  end

  assign RdData  = rd_data_r;
  assign RdValid = rd_valid_r;
  assign Error   = error_r;
  assign DbgData = dbg_data_r;

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// Bench for cvp14_mem_responder: two instances (full-depth/lat 2, depth 256/lat 3)
// share one stimulus stream and are checked every cycle against a timeline model.
module tb_cvp14_mem_responder;

  logic        Clk;
  logic        Reset_n;
  logic        RD, WR;
  logic [15:0] Addr, WrData, DbgAddr;

  logic [15:0] rd_data0, rd_data1, dbg0, dbg1;
  logic        v0, v1, e0, e1;

  int n_cmp = 0;
  int n_bad = 0;

  cvp14_mem_responder #(
    .ADDR_W(16), .DATA_W(16), .DEPTH(65536), .READ_LAT(2)
  ) u_big (
    .Clk(Clk), .Reset_n(Reset_n), .Addr(Addr), .RD(RD), .WR(WR),
    .WrData(WrData), .RdData(rd_data0), .RdValid(v0), .Error(e0),
    .DbgAddr(DbgAddr), .DbgData(dbg0)
  );

  cvp14_mem_responder #(
    .ADDR_W(16), .DATA_W(16), .DEPTH(256), .READ_LAT(3)
  ) u_small (
    .Clk(Clk), .Reset_n(Reset_n), .Addr(Addr), .RD(RD), .WR(WR),
    .WrData(WrData), .RdData(rd_data1), .RdValid(v1), .Error(e1),
    .DbgAddr(DbgAddr), .DbgData(dbg1)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference: memory image plus a time-indexed schedule of read returns.
  int          depth [2] = '{65536, 256};
  int          lat   [2] = '{2, 3};
  bit   [15:0] mm    [2][65536];
  bit          sv    [2][8];
  bit   [15:0] sd    [2][8];
  bit   [15:0] ed    [2];
  bit   [15:0] eg    [2];
  bit          evl   [2];
  bit          eer   [2];
  int unsigned cyc = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ed[i] = 16'h0; eg[i] = 16'h0; evl[i] = 1'b0; eer[i] = 1'b0;
      for (int j = 0; j < 8; j++) sv[i][j] = 1'b0;
    end
  endtask

  task automatic model_step();
    int slot;
    bit inr;
    for (int i = 0; i < 2; i++) begin
      eg[i] = (DbgAddr < depth[i]) ? mm[i][DbgAddr] : 16'h0;
      slot = int'(cyc % 8);
      if (sv[i][slot]) begin
        evl[i] = 1'b1; ed[i] = sd[i][slot]; sv[i][slot] = 1'b0;
      end else begin
        evl[i] = 1'b0;
      end
      inr = (Addr < depth[i]);
      if (RD && !WR) begin
        slot = int'((cyc + lat[i]) % 8);
        sv[i][slot] = 1'b1;
        sd[i][slot] = inr ? mm[i][Addr] : 16'h0;
        if (!inr) eer[i] = 1'b1;
      end
      if (WR) begin
        if (inr) mm[i][Addr] = WrData;
        else     eer[i] = 1'b1;
        if (RD)  eer[i] = 1'b1;
      end
    end
    cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) model_reset();
      else          model_step();
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      check("big_rd_valid",   {15'h0, v0}, {15'h0, evl[0]});
      check("big_rd_data",    rd_data0,    ed[0]);
      check("big_error",      {15'h0, e0}, {15'h0, eer[0]});
      check("big_dbg_data",   dbg0,        eg[0]);
      check("small_rd_valid", {15'h0, v1}, {15'h0, evl[1]});
      check("small_rd_data",  rd_data1,    ed[1]);
      check("small_error",    {15'h0, e1}, {15'h0, eer[1]});
      check("small_dbg_data", dbg1,        eg[1]);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    RD = rd; WR = wr; Addr = a; WrData = d;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    logic [15:0] a;
    int op;
    Reset_n = 1'b0; RD = 1'b0; WR = 1'b0;
    Addr = 16'h0; WrData = 16'h0; DbgAddr = 16'h0;
    repeat (3) tick();
    check("rst_rd_valid", {15'h0, v0}, 16'h0);
    check("rst_rd_data",  rd_data0,    16'h0);
    check("rst_error",    {15'h0, e0}, 16'h0);
    check("rst_dbg",      dbg0,        16'h0);
    Reset_n = 1'b1;
    tick();

    // Write then read-after-write.
    drive(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    drive(1'b1, 1'b0, 16'h0010, 16'h0);
    idle(); idle();
    check("raw_valid", {15'h0, v0}, 16'h1);
    check("raw_data",  rd_data0,    16'hBEEF);
    check("raw_error", {15'h0, e0}, 16'h0);

    // Back-to-back reads return in order.
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 16'(k), 16'(16'h1111 * (k + 1)));
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(1'b1, 1'b0, 16'(k), 16'h0);
      else       idle();
      if (k >= 2) begin
        check("b2b_valid", {15'h0, v0}, 16'h1);
        check("b2b_data",  rd_data0,    16'(16'h1111 * (k - 1)));
      end
    end

    // Snapshot: a write after the read does not alter it.
    drive(1'b0, 1'b1, 16'h0020, 16'hAAAA);
    drive(1'b1, 1'b0, 16'h0020, 16'h0);
    drive(1'b0, 1'b1, 16'h0020, 16'h5555);
    idle();
    check("snap_old", rd_data0, 16'hAAAA);
    drive(1'b1, 1'b0, 16'h0020, 16'h0);
    idle(); idle();
    check("snap_new", rd_data0, 16'h5555);

    // Collision: write performed, no return, sticky error.
    check("coll_err_before", {15'h0, e0}, 16'h0);
    drive(1'b1, 1'b1, 16'h0030, 16'h1234);
    idle(); idle();
    check("coll_no_valid", {15'h0, v0}, 16'h0);
    check("coll_error",    {15'h0, e0}, 16'h1);
    drive(1'b1, 1'b0, 16'h0030, 16'h0);
    idle(); idle();
    check("coll_data",   rd_data0,    16'h1234);
    check("coll_sticky", {15'h0, e0}, 16'h1);

    // Reset mid-read flushes it; a write during reset is lost.
    drive(1'b1, 1'b0, 16'h0010, 16'h0);
    Reset_n = 1'b0;
    RD = 1'b0; WR = 1'b1; Addr = 16'h0010; WrData = 16'hDEAD;
    #1;
    check("mrst_valid", {15'h0, v0}, 16'h0);
    check("mrst_data",  rd_data0,    16'h0);
    check("mrst_error", {15'h0, e0}, 16'h0);
    check("mrst_serr",  {15'h0, e1}, 16'h0);
    tick();
    RD = 1'b0; WR = 1'b0;
    Reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle();
      check("mrst_no_valid", {15'h0, v0 | v1}, 16'h0);
    end
    drive(1'b1, 1'b0, 16'h0010, 16'h0);
    idle(); idle();
    check("mrst_kept_valid", {15'h0, v0}, 16'h1);
    check("mrst_kept_data",  rd_data0,    16'hBEEF);

    // Out-of-range on the 256-word instance; back-door still reads word 0.
    check("oor_err_before", {15'h0, e1}, 16'h0);
    DbgAddr = 16'h0000;
    drive(1'b0, 1'b1, 16'h0100, 16'hFFFF);
    drive(1'b1, 1'b0, 16'h0100, 16'h0);
    idle(); idle(); idle();
    check("oor_valid", {15'h0, v1}, 16'h1);
    check("oor_data",  rd_data1,    16'h0000);
    check("oor_error", {15'h0, e1}, 16'h1);
    check("oor_dbg",   dbg1,        16'h1111);
    check("oor_big_error", {15'h0, e0}, 16'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      DbgAddr = 16'($urandom_range(0, 300));
      case ($urandom_range(0, 3))
        0:       a = 16'($urandom_range(0, 511));
        1:       a = 16'hFFFF;
        default: a = 16'($urandom_range(0, 15));
      endcase
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 299) == 0) begin
        Reset_n = 1'b0;
        RD = 1'($urandom_range(0, 1)); WR = 1'($urandom_range(0, 1));
        Addr = a; WrData = 16'($urandom);
        tick();
        Reset_n = 1'b1;
      end else if (op < 4) begin
        drive(1'b1, 1'b0, a, 16'h0);
      end else if (op < 8) begin
        drive(1'b0, 1'b1, a, 16'($urandom));
      end else if (op == 8) begin
        drive(1'b1, 1'b1, a, 16'($urandom));
      end else begin
        idle();
      end
    end
    idle(); idle(); idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cvp14_mem_responder.md
# cvp14_mem_responder

Single-clock memory responder for the CVP14 bus: it accepts the processor's `Addr`/`RD`/`WR`/`DataOut` strobes and returns read data on `DataIn` with a fixed, parameterised latency. It replaces the two-phase behavioural DRAM in synthesizable and single-clock builds. It sits directly on the CVP14 memory port and also provides a registered back-door read port for bench memory dumps.

## Interface
- `ADDR_W`, 16, address width in words
- `DATA_W`, 16, word width
- `DEPTH`, 65536, implemented words; must satisfy `DEPTH <= 2**ADDR_W`
- `READ_LAT`, 2, cycles from RD sample to data valid; legal range 1..4
- `Clk` in 1: sole clock; everything is rising-edge.
- `Reset_n` in 1: one clock; reset is asynchronous and active-low.
- `Addr` in ADDR_W: word address from CVP14.
- `RD` in 1: read strobe, sampled every cycle.
- `WR` in 1: write strobe, sampled every cycle.
- `WrData` in DATA_W: write data; connects to CVP14 `DataOut`.
- `RdData` out DATA_W: read data; connects to CVP14 `DataIn`.
- `RdValid` out 1: one-cycle pulse marking the cycle in which `RdData` is updated.
- `Error` out 1: sticky protocol/range error.
- `DbgAddr` in ADDR_W: back-door read address.
- `DbgData` out DATA_W: back-door data, registered with 1-cycle latency.

## Operation
- Bus operation is decoded per cycle from {RD, WR}:
  - 00: IDLE.
  - 10: READ.
  - 01: WRITE.
  - 11: COLLISION.
- WRITE:
  - The array is written at the sampling edge.
  - If `Addr >= DEPTH`, the write is dropped and `Error` is set.
- READ:
  - The array is read at the sampling edge, giving snapshot semantics: a later write to the same address does not alter an in-flight read.
  - The word enters a READ_LAT-deep pipeline.
  - `Addr >= DEPTH` loads 0 into the pipeline and sets `Error`.
- COLLISION:
  - The write is performed and the read is ignored (no pipeline entry).
  - `Error` is set.
- A new READ is accepted every cycle. The pipeline is fully pipelined, with no back-pressure and no ready signal, because CVP14 relies on fixed timing.
- When a pipeline entry reaches its final stage:
  - `RdData` takes its value and `RdValid` pulses.
  - Otherwise `RdData` holds its last value and `RdValid` is 0.
- `Error` clears only on reset.
- `DbgData` is the word at `DbgAddr` one cycle later; out-of-range addresses return 0. The back-door port never affects `Error` or the bus.
- Array contents are NOT reset. The simulation initial value is 0.

## Timing
- Reset values: `RdData`=0, `RdValid`=0, `Error`=0, `DbgData`=0, all pipeline valid bits 0.
- Assertion of `Reset_n` low mid-read flushes all in-flight reads; no `RdValid` is produced for them.
- A write sampled in the same edge as reset assertion is lost.
- Read latency: RD sampled at edge N means `RdData`/`RdValid` are updated at edge N+READ_LAT.
- Read-after-write: WR at edge N, RD of the same address at edge N+1 returns the new data. The array is written before the next edge's read.
- Read and write to the same address at the same edge (COLLISION) is an error, handled as above.
- Back-to-back reads at edges N, N+1, N+2 return data at N+L, N+L+1, N+L+2, in order.
- Address wrap: there is no wrap. Any address ≥ DEPTH is an out-of-range access.

## Structure
- Package `cvp14_mem_pkg` contains:
  - `ADDR_W` and `DATA_W` default localparams.
  - Bus-op enum `bus_op_t` = {BUS_IDLE, BUS_READ, BUS_WRITE, BUS_COLL}.
  - Legal `READ_LAT` bounds.
- Sub-module `mem_rd_pipe` is a parameterised valid+data shift register of depth READ_LAT, with async active-low flush. The top module holds the array, op decode, the error flag and the debug port.

## Test plan
- Reset release, then WR Addr=0x0010 Data=0xBEEF, then RD 0x0010 on the next cycle → with READ_LAT=2, `RdData`=0xBEEF and `RdValid`=1 exactly 2 edges after the RD; `Error`=0.
- Pre-load 0x0000..0x0003 with 0x1111..0x4444, then issue 4 back-to-back RDs → 4 consecutive `RdValid` pulses carrying 0x1111, 0x2222, 0x3333, 0x4444 in order.
- RD 0x0020 (holding 0xAAAA), then WR 0x0020=0x5555 on the next cycle → the read returns 0xAAAA; a later RD returns 0x5555.
- RD and WR both high, Addr=0x0030, WrData=0x1234 → no `RdValid`, `Error`=1 sticky; a later RD 0x0030 returns 0x1234.
- DEPTH=256: WR 0x0100=0xFFFF, then RD 0x0100 → `RdData`=0x0000, `Error`=1; `DbgAddr`=0x0000 still returns its stored word.
- Issue RD, then drop `Reset_n` one cycle later for one cycle → no `RdValid` follows; all outputs are 0; array contents are preserved, as shown by a subsequent RD.
